icepic_prog_loader: RTL and testbench

//  Byte-stream program loader for the iCEPIC core: writer side of the 12-bit instruction interface.

---
 rtl/icepic_lib_pkg.sv | 27 ++
 rtl/icepic_prog_loader_if.sv | 31 +++
 rtl/icepic_prog_loader.sv | 164 ++++++++++++++++
 tb/tb_icepic_prog_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/icepic_lib_pkg.sv
// Shared iCEPIC types: instruction word, program-loader states and link bytes.
package icepic_lib_pkg;

  typedef logic [11:0] inst_t;

  typedef enum logic [2:0] {
    IDLE,
    A_LO,
    A_HI,
    CNT,
    D_LO,
    D_HI,
    CSUM,
    RESP
  } loader_state_t;

  localparam logic [7:0] LDR_SYNC = 8'hA5;
  localparam logic [7:0] LDR_RUN  = 8'h5A;
  localparam logic [7:0] LDR_ACK  = 8'h06;
  localparam logic [7:0] LDR_NAK  = 8'h15;

  // A COUNT byte of zero encodes a full 256-word burst.
  function automatic logic [8:0] word_count(input logic [7:0] cnt);
    return (cnt == 8'd0) ? 9'd256 : {1'b0, cnt};
  endfunction

endpackage

// File: rtl/icepic_prog_loader_if.sv
// Host byte link, response link and program-memory write port of the loader.
interface icepic_prog_loader_if
  import icepic_lib_pkg::*;
#(
  parameter int ADDR_W = 9
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              pmem_we;
  logic [ADDR_W-1:0] pmem_addr;
  inst_t             pmem_wdata;
  logic              core_hold;
  logic              busy;
  logic              load_err;

  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output rx_ready, tx_valid, tx_data, pmem_we, pmem_addr, pmem_wdata,
           core_hold, busy, load_err
  );

  modport master (
    output rx_valid, rx_data, tx_ready,
    input  rx_ready, tx_valid, tx_data, pmem_we, pmem_addr, pmem_wdata,
           core_hold, busy, load_err
  );
endinterface

// File: rtl/icepic_prog_loader.sv
// Framed byte-stream program loader: writes instruction words into program memory,
// holds the core in reset while loading and answers each frame or RUN with ACK/NAK.
module icepic_prog_loader
  import icepic_lib_pkg::*;
#(
  parameter int          ADDR_W    = 9,
  parameter logic [23:0] TIMEOUT   = 24'd1000000,
  parameter logic [7:0]  SYNC_BYTE = LDR_SYNC,
  parameter logic [7:0]  RUN_BYTE  = LDR_RUN,
  parameter logic [7:0]  ACK_BYTE  = LDR_ACK,
  parameter logic [7:0]  NAK_BYTE  = LDR_NAK
) (
  input  logic                clk,
  input  logic                rst,
  icepic_prog_loader_if.slave bus
);

  loader_state_t     state, state_nxt;
  logic [23:0]       tmo, tmo_nxt;
  logic              frame_err, frame_err_nxt;
  logic [8:0]        rem, rem_nxt;
  logic              we_r, we_nxt;
  logic [ADDR_W-1:0] waddr_r, waddr_nxt;
  inst_t             wdata_r, wdata_nxt;
  logic [7:0]        txd_r, txd_nxt;
  logic              hold_r, hold_nxt;
  logic              lerr_r, lerr_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [7:0]        lo_byte, lo_nxt;
  logic [7:0]        csum, csum_nxt, csum_add;
  logic [15:0]       a_full;
  logic              hs, in_frame;

  assign bus.rx_ready   = (state != RESP);
  assign bus.tx_valid   = (state == RESP);
  assign bus.tx_data    = txd_r;
  assign bus.pmem_we    = we_r;
  assign bus.pmem_addr  = waddr_r;
  assign bus.pmem_wdata = wdata_r;
  assign bus.core_hold  = hold_r;
  assign bus.busy       = (state != IDLE);
  assign bus.load_err   = lerr_r;

  assign hs       = bus.rx_valid & bus.rx_ready;
  assign in_frame = state inside {A_LO, A_HI, CNT, D_LO, D_HI, CSUM};
  assign csum_add = csum + bus.rx_data;
  assign a_full   = {bus.rx_data, lo_byte};

  always_comb begin
    state_nxt     = state;
    tmo_nxt       = (in_frame && !hs) ? tmo + 24'd1 : 24'd0;
    frame_err_nxt = frame_err;
    rem_nxt       = rem;
    we_nxt        = 1'b0;
    waddr_nxt     = waddr_r;
    wdata_nxt     = wdata_r;
    txd_nxt       = txd_r;
    hold_nxt      = hold_r;
    lerr_nxt      = lerr_r;
    addr_nxt      = addr;
    lo_nxt        = lo_byte;
    csum_nxt      = csum;
    case (state)
      IDLE: if (hs) begin
        if (bus.rx_data == SYNC_BYTE) begin
          state_nxt     = A_LO;
          hold_nxt      = 1'b1;
          lerr_nxt      = 1'b0;
          frame_err_nxt = 1'b0;
          csum_nxt      = 8'd0;
        end else if (bus.rx_data == RUN_BYTE) begin
          state_nxt = RESP;
          hold_nxt  = 1'b0;
          txd_nxt   = ACK_BYTE;
        end
      end
      A_LO: if (hs) begin
        lo_nxt    = bus.rx_data;
        csum_nxt  = csum_add;
        state_nxt = A_HI;
      end
      A_HI: if (hs) begin
        addr_nxt  = a_full[ADDR_W-1:0];
        csum_nxt  = csum_add;
        state_nxt = CNT;
        if ((a_full >> ADDR_W) != 16'd0) frame_err_nxt = 1'b1;
      end
      CNT: if (hs) begin
        rem_nxt   = word_count(bus.rx_data);
        csum_nxt  = csum_add;
        state_nxt = D_LO;
      end
      D_LO: if (hs) begin
        lo_nxt    = bus.rx_data;
        csum_nxt  = csum_add;
        state_nxt = D_HI;
      end
      D_HI: if (hs) begin
        // A malformed HI byte drops the word but still consumes its address slot.
        if (bus.rx_data[7:4] == 4'd0) begin
          we_nxt    = 1'b1;
          waddr_nxt = addr;
          wdata_nxt = {bus.rx_data[3:0], lo_byte};
        end else begin
          frame_err_nxt = 1'b1;
        end
        addr_nxt  = addr + ADDR_W'(1);
        rem_nxt   = rem - 9'd1;
        csum_nxt  = csum_add;
        state_nxt = (rem == 9'd1) ? CSUM : D_LO;
      end
      CSUM: if (hs) begin
        state_nxt = RESP;
        if (frame_err || csum_add != 8'd0) begin
          txd_nxt  = NAK_BYTE;
          lerr_nxt = 1'b1;
        end else begin
          txd_nxt  = ACK_BYTE;
        end
      end
      RESP: if (bus.tx_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // An accepted byte in the same cycle always beats the timeout.
    if (in_frame && !hs && tmo == TIMEOUT - 24'd1) begin
      state_nxt = RESP;
      txd_nxt   = NAK_BYTE;
      lerr_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tmo       <= 24'd0;
      frame_err <= 1'b0;
      rem       <= 9'd0;
      we_r      <= 1'b0;
      waddr_r   <= '0;
      wdata_r   <= '0;
      txd_r     <= 8'd0;
      hold_r    <= 1'b1;
      lerr_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmo       <= tmo_nxt;
      frame_err <= frame_err_nxt;
      rem       <= rem_nxt;
      we_r      <= we_nxt;
      waddr_r   <= waddr_nxt;
      wdata_r   <= wdata_nxt;
      txd_r     <= txd_nxt;
      hold_r    <= hold_nxt;
      lerr_r    <= lerr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    addr    <= addr_nxt;
    lo_byte <= lo_nxt;
    csum    <= csum_nxt;
  end

endmodule

// File: tb/tb_icepic_prog_loader.sv
// Directed bench for the program loader: frames, checksum/format errors, wrap, timeout, RUN, reset.
module tb_icepic_prog_loader;
  import icepic_lib_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [7:0]  fr[$];
  logic [8:0]  log_addr[$];
  logic [11:0] log_data[$];
  logic [7:0]  r;
  int          bad;

  icepic_prog_loader_if #(.ADDR_W(9)) bus ();

  icepic_prog_loader #(.ADDR_W(9), .TIMEOUT(24'd100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.pmem_we) begin
      log_addr.push_back(bus.pmem_addr);
      log_data.push_back(bus.pmem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.rx_ready) check_eq("rx_ready_wait", bus.rx_ready, 1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int from);
    for (int i = from; i < fr.size(); i++) send_byte(fr[i]);
  endtask

  task automatic get_resp(output logic [7:0] d);
    int n;
    n = 0;
    while (!bus.tx_valid && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("tx_valid_seen", bus.tx_valid, 1);
    d = bus.tx_data;
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    check_eq("busy_after_resp", bus.busy, 0);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rx_ready", bus.rx_ready, 1);
    check_eq("rst_tx_valid", bus.tx_valid, 0);
    check_eq("rst_tx_data", bus.tx_data, 0);
    check_eq("rst_pmem_we", bus.pmem_we, 0);
    check_eq("rst_pmem_addr", bus.pmem_addr, 0);
    check_eq("rst_pmem_wdata", bus.pmem_wdata, 0);
    check_eq("rst_core_hold", bus.core_hold, 1);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_load_err", bus.load_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Good two-word frame
    clear_log();
    fr = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h0A, 8'h0C, 8'h01, 8'h00, 8'hD7};
    send_frame(0);
    get_resp(r);
    check_eq("t1_resp", r, LDR_ACK);
    check_eq("t1_nwr", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check_eq("t1_a0", log_addr[0], 9'h010);
      check_eq("t1_d0", log_data[0], 12'hC0A);
      check_eq("t1_a1", log_addr[1], 9'h011);
      check_eq("t1_d1", log_data[1], 12'h001);
    end
    check_eq("t1_load_err", bus.load_err, 0);
    check_eq("t1_core_hold", bus.core_hold, 1);

    // Bad checksum still writes, then NAKs
    clear_log();
    fr = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h0A, 8'h0C, 8'h01, 8'h00, 8'hD8};
    send_frame(0);
    get_resp(r);
    check_eq("t2_resp", r, LDR_NAK);
    check_eq("t2_nwr", log_addr.size(), 2);
    check_eq("t2_load_err", bus.load_err, 1);

    // Address wrap at 0x1FF; SYNC clears load_err
    clear_log();
    fr = '{8'hA5, 8'hFF, 8'h01, 8'h02, 8'h34, 8'h02, 8'h78, 8'h05, 8'h4B};
    send_byte(fr[0]);
    check_eq("t3_sync_clr_err", bus.load_err, 0);
    send_frame(1);
    get_resp(r);
    check_eq("t3_resp", r, LDR_ACK);
    check_eq("t3_nwr", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check_eq("t3_a0", log_addr[0], 9'h1FF);
      check_eq("t3_d0", log_data[0], 12'h234);
      check_eq("t3_a1", log_addr[1], 9'h000);
      check_eq("t3_d1", log_data[1], 12'h578);
    end

    // Malformed HI byte skips that word
    clear_log();
    fr = '{8'hA5, 8'h20, 8'h00, 8'h02, 8'h11, 8'h01, 8'h22, 8'h1F, 8'h8B};
    send_frame(0);
    get_resp(r);
    check_eq("t3b_resp", r, LDR_NAK);
    check_eq("t3b_nwr", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      check_eq("t3b_a0", log_addr[0], 9'h020);
      check_eq("t3b_d0", log_data[0], 12'h111);
    end
    check_eq("t3b_load_err", bus.load_err, 1);

    // Address beyond ADDR_W bits
    clear_log();
    fr = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h00, 8'h00, 8'hFD};
    send_frame(0);
    get_resp(r);
    check_eq("t3c_resp", r, LDR_NAK);
    check_eq("t3c_nwr", log_addr.size(), 1);

    // Stall after COUNT until timeout
    clear_log();
    fr = '{8'hA5, 8'h10, 8'h00, 8'h02};
    send_frame(0);
    check_eq("t4_busy", bus.busy, 1);
    get_resp(r);
    check_eq("t4_resp", r, LDR_NAK);
    check_eq("t4_nwr", log_addr.size(), 0);
    check_eq("t4_load_err", bus.load_err, 1);
    check_eq("t4_core_hold", bus.core_hold, 1);

    // RUN with a stalled response sink
    check_eq("t5_hold_before", bus.core_hold, 1);
    send_byte(LDR_RUN);
    check_eq("t5_hold_after", bus.core_hold, 0);
    bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (!bus.tx_valid || bus.tx_data != LDR_ACK || bus.rx_ready) bad++;
    end
    check_eq("t5_stall_unstable", bad, 0);
    get_resp(r);
    check_eq("t5_resp", r, LDR_ACK);

    // Reset while waiting for a HI byte
    clear_log();
    fr = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h0A};
    send_frame(0);
    check_eq("t6_busy_mid", bus.busy, 1);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h0C;
    rst = 1'b1;
    #1;
    check_eq("t6_busy", bus.busy, 0);
    check_eq("t6_rx_ready", bus.rx_ready, 1);
    check_eq("t6_tx_valid", bus.tx_valid, 0);
    check_eq("t6_pmem_addr", bus.pmem_addr, 0);
    check_eq("t6_pmem_wdata", bus.pmem_wdata, 0);
    check_eq("t6_core_hold", bus.core_hold, 1);
    repeat (2) @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t6_nwr", log_addr.size(), 0);
    check_eq("t6_tx_idle", bus.tx_valid, 0);
    fr = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h0A, 8'h0C, 8'h01, 8'h00, 8'hD7};
    send_frame(0);
    get_resp(r);
    check_eq("t6_resp", r, LDR_ACK);
    check_eq("t6_nwr2", log_addr.size(), 2);
    if (log_addr.size() == 2) check_eq("t6_d1", log_data[1], 12'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
